pcq_pm_thold_seq: RTL and testbench
===================================

PCQ_PM_THOLD_SEQ -- requirements
Module: pcq_pm_thold_seq

Interface
REQ-001 SHALL have parameter STAGES, default 3, meaning the number of thold groups sequenced (bit 0 = func, 1 = func_slp, 2 = ary).
REQ-002 SHALL have parameter DLY_WIDTH, default 4, meaning the width of the per-stage delay field.
REQ-003 SHALL have one clock and an asynchronous active-low reset: nclk  in  1  rising-edge clock.
REQ-004 rst_b  in  1  asynchronous active-low reset.
REQ-005 pm_raise_tholds  in  1  level request from the PM controller to raise tholds.
REQ-006 pm_ccflush_disable  in  1  level, PM controller ccflush-disable request.
REQ-007 dis_pwr_savings  in  1  level override; when 1, power savings are forbidden.
REQ-008 stage_dly  in  DLY_WIDTH  stage spacing D; stages occur every D+1 cycles.
REQ-009 pm_tholds  out  STAGES  per-group thold raise, bit 0 first.
REQ-010 ccflush_disable_out  out  1  ccflush disable to the clock-control macro.
REQ-011 tholds_up  out  1  all tholds raised and settled (HELD).
REQ-012 tholds_down  out  1  no thold raised (IDLE).
REQ-013 sleep_cnt  out  4  saturating count of HELD entries.
REQ-014 dbg_seq  out  8  {state[1:0], pm_tholds[0:2], req_q, cnt_zero, dis_pwr_savings}.

Function
REQ-015 FSM states SHALL be IDLE, RAISE, HELD, LOWER, with registered outputs only.
REQ-016 req SHALL be defined as pm_raise_tholds & pm_ccflush_disable & ~dis_pwr_savings; req_q is req registered one cycle.
REQ-017 IDLE->RAISE SHALL occur on the edge where req_q=1; on that edge pm_tholds[0] is set, D is latched into dly_q, and the counter is loaded with dly_q.
REQ-018 In RAISE and LOWER the counter SHALL decrement each cycle while it is nonzero; an event fires on the edge where the counter is 0, and the counter reloads dly_q.
REQ-019 A RAISE event SHALL set the next clear pm_tholds bit in ascending order; if all bits are already set, the FSM goes to HELD, sets tholds_up, and increments sleep_cnt (saturating at 15).
REQ-020 With request held and D=2 sampled at edge t, tholds SHALL appear in this order: bit 0 at t+1, bit 1 at t+4, bit 2 at t+7, HELD at t+10.
REQ-021 HELD->LOWER SHALL occur on the edge where req_q=0.
REQ-022 On that edge the highest set bit SHALL clear, D is relatched into dly_q, and the counter is loaded.
REQ-023 RAISE->LOWER SHALL occur on the edge where req_q=0 mid-raise; LOWER starts by clearing the highest currently set bit, with no further raising.
REQ-024 A LOWER event SHALL clear the highest set bit; LOWER->IDLE occurs on the same edge bit 0 clears.
REQ-025 req_q reasserting during LOWER SHALL be ignored until IDLE; re-entry to RAISE is possible at the earliest one cycle after IDLE.
REQ-026 stage_dly changes SHALL take effect only at the next RAISE or LOWER entry.
REQ-027 D=0 SHALL give one stage per cycle; D=max gives 2^DLY_WIDTH cycles per stage, with no wrap.
REQ-028 ccflush_disable_out SHALL be pm_ccflush_disable_q | (state != IDLE), so it stays asserted until all tholds are lowered.
REQ-029 tholds_down SHALL equal (state == IDLE); tholds_up SHALL equal (state == HELD); the two are never both 1.
REQ-030 pm_tholds SHALL only change on stage events or reset, never in IDLE or HELD.

Reset
REQ-031 While rst_b=0, the block SHALL asynchronously force: state=IDLE, pm_tholds=0, counter=0, dly_q=0, req_q=0, sleep_cnt=0, tholds_up=0, tholds_down=1, ccflush_disable_out=0.
REQ-032 Reset asserted mid-RAISE, HELD or LOWER SHALL drop all tholds immediately, with no sequenced lowering.
REQ-033 After rst_b deassertion, the first state change SHALL be no earlier than the second rising edge.

Verification
REQ-034 Scenario D=2, req held: bit 0 at t+1, bit 1 at t+4, bit 2 at t+7, tholds_up at t+10, sleep_cnt=1.
REQ-035 Scenario req dropped in HELD with D=0: pm_tholds goes 111->011->001->000 on consecutive edges, tholds_down=1 with the last clear, ccflush_disable_out=0 the next cycle if pm_ccflush_disable=0.
REQ-036 Scenario req dropped after bit 1 is set, D=1: bit 1 clears on the LOWER entry edge, bit 0 clears 2 cycles later, then IDLE, and bit 2 never sets.
REQ-037 Scenario dis_pwr_savings=1 with raise and ccflush requested: FSM stays IDLE, pm_tholds=0, ccflush_disable_out follows pm_ccflush_disable; asserting dis_pwr_savings in HELD triggers LOWER.
REQ-038 Scenario 16 raise/lower cycles: sleep_cnt saturates at 15; a req pulse during LOWER is ignored until IDLE.
REQ-039 Scenario rst_b pulsed low in HELD: pm_tholds=0 and tholds_down=1 asynchronously, before the next edge.

Source files
------------

// File: rtl/pcq_pm_thold_seq.sv
// rtl/pcq_pm_thold_seq.sv - power-management thold raise/lower sequencer
// Raises thold groups in ascending order every D+1 cycles and lowers them in reverse.
module pcq_pm_thold_seq #(
  parameter int STAGES    = 3,
  parameter int DLY_WIDTH = 4
) (
  input  logic                 nclk,
  input  logic                 rst_b,
  input  logic                 pm_raise_tholds,
  input  logic                 pm_ccflush_disable,
  input  logic                 dis_pwr_savings,
  input  logic [DLY_WIDTH-1:0] stage_dly,
  output logic [STAGES-1:0]    pm_tholds,
  output logic                 ccflush_disable_out,
  output logic                 tholds_up,
  output logic                 tholds_down,
  output logic [3:0]           sleep_cnt,
  output logic [7:0]           dbg_seq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    HELD  = 2'd2,
    LOWER = 2'd3
  } state_t;

  localparam int PW = (STAGES > 3) ? STAGES : 3;

  state_t               state, state_d;
  logic                 req, req_q, cc_q, cnt_zero;
  logic [DLY_WIDTH-1:0] dly_q, dly_d, cnt, cnt_d;
  logic [STAGES-1:0]    tholds_d, tholds_lo, tholds_hi;
  logic [3:0]           sleep_d;
  logic [PW-1:0]        th_pad;

  assign req       = pm_raise_tholds & pm_ccflush_disable & ~dis_pwr_savings;
  assign cnt_zero  = (cnt == '0);
  // Tholds always fill contiguously from bit 0, so shifts give next-up / next-down.
  assign tholds_lo = pm_tholds >> 1;
  assign tholds_hi = (pm_tholds << 1) | STAGES'(1);

  always_comb begin
    state_d  = state;
    tholds_d = pm_tholds;
    cnt_d    = cnt;
    dly_d    = dly_q;
    sleep_d  = sleep_cnt;
    case (state)
      IDLE: begin
        if (req_q) begin
          state_d  = RAISE;
          tholds_d = STAGES'(1);
          dly_d    = stage_dly;
          cnt_d    = stage_dly;
        end
      end
      RAISE: begin
        if (!req_q) begin
          tholds_d = tholds_lo;
          dly_d    = stage_dly;
          cnt_d    = stage_dly;
          state_d  = (tholds_lo == '0) ? IDLE : LOWER;
        end else if (!cnt_zero) begin
          cnt_d = cnt - 1'b1;
        end else begin
          cnt_d = dly_q;
          if (&pm_tholds) begin
            state_d = HELD;
            sleep_d = (sleep_cnt == 4'hF) ? sleep_cnt : sleep_cnt + 4'd1;
          end else begin
            tholds_d = tholds_hi;
          end
        end
      end
      HELD: begin
        if (!req_q) begin
          tholds_d = tholds_lo;
          dly_d    = stage_dly;
          cnt_d    = stage_dly;
          state_d  = (tholds_lo == '0) ? IDLE : LOWER;
        end
      end
      LOWER: begin
        // Requests are ignored here; lowering always runs to completion.
        if (!cnt_zero) begin
          cnt_d = cnt - 1'b1;
        end else begin
          cnt_d    = dly_q;
          tholds_d = tholds_lo;
          if (tholds_lo == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      pm_tholds <= '0;
      cnt       <= '0;
      dly_q     <= '0;
      req_q     <= 1'b0;
      cc_q      <= 1'b0;
      sleep_cnt <= 4'd0;
    end else begin
      state     <= state_d;
      pm_tholds <= tholds_d;
      cnt       <= cnt_d;
      dly_q     <= dly_d;
      req_q     <= req;
      cc_q      <= pm_ccflush_disable;
      sleep_cnt <= sleep_d;
    end
  end

  assign ccflush_disable_out = cc_q | (state != IDLE);
  assign tholds_up           = (state == HELD);
  assign tholds_down         = (state == IDLE);
  assign th_pad              = PW'(pm_tholds);
  assign dbg_seq = {state, th_pad[0], th_pad[1], th_pad[2], req_q, cnt_zero, dis_pwr_savings};

endmodule

// File: tb/tb_pcq_pm_thold_seq.sv
// tb/tb_pcq_pm_thold_seq.sv - randomized self-checking bench for pcq_pm_thold_seq
// Reference model tracks raised level and absolute event timestamps.
module tb_pcq_pm_thold_seq;

  logic       nclk = 1'b0;
  logic       rst_b;
  logic       pm_raise_tholds, pm_ccflush_disable, dis_pwr_savings;
  logic [3:0] stage_dly;
  logic [2:0] pm_tholds;
  logic       ccflush_disable_out, tholds_up, tholds_down;
  logic [3:0] sleep_cnt;
  logic [7:0] dbg_seq;

  pcq_pm_thold_seq #(.STAGES(3), .DLY_WIDTH(4)) dut (
    .nclk                (nclk),
    .rst_b               (rst_b),
    .pm_raise_tholds     (pm_raise_tholds),
    .pm_ccflush_disable  (pm_ccflush_disable),
    .dis_pwr_savings     (dis_pwr_savings),
    .stage_dly           (stage_dly),
    .pm_tholds           (pm_tholds),
    .ccflush_disable_out (ccflush_disable_out),
    .tholds_up           (tholds_up),
    .tholds_down         (tholds_down),
    .sleep_cnt           (sleep_cnt),
    .dbg_seq             (dbg_seq)
  );

  always #5 nclk = ~nclk;

  int checks = 0;
  int errors = 0;

  localparam int PH_IDLE = 0, PH_RAISE = 1, PH_HELD = 2, PH_LOWER = 3;
  int cyc, m_ph, m_lvl, m_next, m_dly, m_sleep, m_reqq, m_ccq;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_lvl = 0; m_next = 0; m_dly = 0;
    m_sleep = 0; m_reqq = 0; m_ccq = 0;
  endtask

  task automatic start_lower();
    m_lvl  = m_lvl - 1;
    m_dly  = int'(stage_dly);
    m_next = cyc + m_dly + 1;
    m_ph   = (m_lvl == 0) ? PH_IDLE : PH_LOWER;
  endtask

  task automatic model_edge();
    int r;
    r = m_reqq;
    case (m_ph)
      PH_IDLE: if (r != 0) begin
        m_ph = PH_RAISE; m_lvl = 1;
        m_dly = int'(stage_dly); m_next = cyc + m_dly + 1;
      end
      PH_RAISE: begin
        if (r == 0) start_lower();
        else if (cyc == m_next) begin
          if (m_lvl == 3) begin
            m_ph = PH_HELD;
            m_sleep = (m_sleep < 15) ? m_sleep + 1 : 15;
          end else m_lvl++;
          m_next = cyc + m_dly + 1;
        end
      end
      PH_HELD: if (r == 0) start_lower();
      default: if (cyc == m_next) begin
        m_lvl--;
        if (m_lvl == 0) m_ph = PH_IDLE;
        m_next = cyc + m_dly + 1;
      end
    endcase
    m_reqq = int'(pm_raise_tholds & pm_ccflush_disable & ~dis_pwr_savings);
    m_ccq  = int'(pm_ccflush_disable);
  endtask

  task automatic compare();
    int t, dbg_t;
    t = (1 << m_lvl) - 1;
    dbg_t = ((t & 1) << 2) | (((t >> 1) & 1) << 1) | ((t >> 2) & 1);
    chk("pm_tholds", int'(pm_tholds), t);
    chk("tholds_up", int'(tholds_up), int'(m_ph == PH_HELD));
    chk("tholds_down", int'(tholds_down), int'(m_ph == PH_IDLE));
    chk("ccflush_out", int'(ccflush_disable_out), int'(m_ccq != 0 || m_ph != PH_IDLE));
    chk("sleep_cnt", int'(sleep_cnt), m_sleep);
    chk("dbg_tholds", int'(dbg_seq[5:3]), dbg_t);
    chk("dbg_req_q", int'(dbg_seq[2]), m_reqq);
    chk("dbg_dis", int'(dbg_seq[0]), int'(dis_pwr_savings));
  endtask

  task automatic cyc_step(input logic pr, input logic pc, input logic dis, input int d);
    @(negedge nclk);
    pm_raise_tholds    = pr;
    pm_ccflush_disable = pc;
    dis_pwr_savings    = dis;
    stage_dly          = 4'(d);
    @(posedge nclk);
    cyc++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    @(negedge nclk);
    pm_raise_tholds = 1'b0; pm_ccflush_disable = 1'b0; dis_pwr_savings = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    chk("rst_tholds", int'(pm_tholds), 0);
    chk("rst_down", int'(tholds_down), 1);
    chk("rst_up", int'(tholds_up), 0);
    chk("rst_ccflush", int'(ccflush_disable_out), 0);
    chk("rst_sleep", int'(sleep_cnt), 0);
    model_reset();
    @(negedge nclk);
    rst_b = 1'b1;
  endtask

  initial begin
    int n, len;
    logic pr, pc, dis;
    cyc = 0;
    model_reset();
    rst_b = 1'b0;
    pm_raise_tholds = 1'b0; pm_ccflush_disable = 1'b0; dis_pwr_savings = 1'b0;
    stage_dly = 4'd0;
    repeat (3) @(posedge nclk);
    do_reset();

    for (int i = 0; i < 14; i++) cyc_step(1'b1, 1'b1, 1'b0, 2);
    chk("d2_sleep", int'(sleep_cnt), 1);
    chk("d2_up", int'(tholds_up), 1);
    for (int i = 0; i < 6; i++) cyc_step(1'b0, 1'b0, 1'b0, 0);
    chk("d0_down", int'(tholds_down), 1);

    for (int i = 0; i < 5; i++) cyc_step(1'b1, 1'b1, 1'b0, 1);
    chk("mid_raise_bits", int'(pm_tholds), 3);
    for (int i = 0; i < 6; i++) cyc_step(1'b0, 1'b1, 1'b0, 1);

    for (int i = 0; i < 5; i++) cyc_step(1'b1, 1'b1, 1'b1, 3);
    chk("dis_idle", int'(tholds_down), 1);
    for (int i = 0; i < 8; i++) cyc_step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc_step(1'b1, 1'b1, 1'b1, 0);

    do_reset();
    for (int k = 0; k < 16; k++) begin
      n = 0;
      while (tholds_up !== 1'b1 && n < 12) begin cyc_step(1'b1, 1'b1, 1'b0, 0); n++; end
      chk("held_reach", int'(tholds_up), 1);
      cyc_step(1'b0, 1'b1, 1'b0, 3);
      cyc_step(1'b1, 1'b1, 1'b0, 3);
      n = 0;
      while (tholds_down !== 1'b1 && n < 20) begin cyc_step(1'b0, 1'b1, 1'b0, 3); n++; end
      chk("idle_reach", int'(tholds_down), 1);
    end
    chk("sleep_sat", int'(sleep_cnt), 15);

    for (int b = 0; b < 40; b++) begin
      pr  = ($urandom_range(0, 3) != 0);
      pc  = ($urandom_range(0, 5) != 0);
      dis = ($urandom_range(0, 9) == 0);
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++)
        cyc_step(pr, pc, dis, ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3));
    end

    n = 0;
    while (tholds_up !== 1'b1 && n < 30) begin cyc_step(1'b1, 1'b1, 1'b0, 1); n++; end
    chk("held_before_rst", int'(tholds_up), 1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc_step(1'b1, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
